// File: rtl/sram_ctrl_if.sv
// sram_ctrl_if: bundles the MEM-stage request/response signals and the
// external asynchronous SRAM pins of the data-memory controller.
//
//   wr_en, rd_en      store / load request from the MEM stage
//   address           byte address (ALU result)
//   write_data        store data (Rm value)
//   read_data         assembled 32-bit load data
//   ready             1 = MEM stage may advance, 0 = freeze pipeline
//   sram_addr         SRAM half-word address
//   sram_dq_out       write data driven towards the SRAM
//   sram_dq_oe        enable for the external DQ tristate driver
//   sram_dq_in        DQ bus value sampled back from the SRAM
//   sram_we_n         SRAM write enable, active-low
//
// modport master: the environment (core MEM stage plus SRAM pads).
// modport slave : the controller itself.
interface sram_ctrl_if;
    logic        wr_en;
    logic        rd_en;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        ready;
    logic [17:0] sram_addr;
    logic [15:0] sram_dq_out;
    logic        sram_dq_oe;
    logic [15:0] sram_dq_in;
    logic        sram_we_n;

    modport master (
        output wr_en, rd_en, address, write_data, sram_dq_in,
        input  read_data, ready, sram_addr, sram_dq_out, sram_dq_oe, sram_we_n
    );

    modport slave (
        input  wr_en, rd_en, address, write_data, sram_dq_in,
        output read_data, ready, sram_addr, sram_dq_out, sram_dq_oe, sram_we_n
    );
endinterface

// File: rtl/sram_ctrl.sv
// sram_ctrl: data-memory controller below the MEM stage. A 32-bit load or
// store becomes two 16-bit accesses (low half, then high half) on an
// external asynchronous SRAM, each holding the bus for ACCESS_CYCLES clocks.
// ready stays low for the whole transaction and pulses high for one DONE
// cycle, during which the assembled read_data is valid.
//
// Ports:
//   clk   single clock, rising edge
//   rst   asynchronous active-low reset
//   bus   sram_ctrl_if.slave (request, response and SRAM pins)
//
// Parameters:
//   ACCESS_CYCLES  clocks per half-access, 2..15
//   MEM_BASE       byte address mapped to SRAM word 0
module sram_ctrl #(
    parameter int unsigned ACCESS_CYCLES = 2,
    parameter logic [31:0] MEM_BASE      = 32'd1024
) (
    input  logic       clk,
    input  logic       rst,
    sram_ctrl_if.slave bus
);

    localparam int unsigned   CW   = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(ACCESS_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t        state, state_d;
    logic [CW-1:0] cnt, cnt_d;

    logic          req;
    logic          last;
    logic [31:0]   offset;
    logic          unused_offset_bits;

    // captured transaction
    logic [16:0]   word_q;
    logic [31:0]   wdata_q;
    logic          is_write_q;

    // transaction view for the upcoming cycle (fresh inputs when leaving IDLE)
    logic [16:0]   word_sel;
    logic [31:0]   wdata_sel;
    logic          write_sel;

    // registered SRAM pins and their next values
    logic [17:0]   addr_q, addr_d;
    logic [15:0]   dq_q, dq_d;
    logic          oe_q, oe_d;
    logic          we_n_q, we_n_d;
    logic [31:0]   rd_q;
    logic          ready;

    assign req    = bus.wr_en | bus.rd_en;
    assign last   = (cnt == LAST);
    assign offset = bus.address - MEM_BASE;

    // byte-lane bits and address bits above the SRAM size carry no meaning
    assign unused_offset_bits = ^{offset[31:19], offset[1:0]};

    // ---------------------------------------------------------------
    // State register
    // ---------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
        end
    end

    // ---------------------------------------------------------------
    // Next-state logic
    // ---------------------------------------------------------------
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        unique case (state)
            IDLE: begin
                if (req) begin
                    state_d = LO;
                    cnt_d   = '0;
                end
            end
            LO: begin
                if (last) begin
                    state_d = HI;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt + CW'(1);
                end
            end
            HI: begin
                if (last) begin
                    state_d = DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt + CW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // ---------------------------------------------------------------
    // Output logic. The SRAM pins are registered, so their next values
    // are derived from the next state/count: this puts the address and
    // WE on the bus in the first LO cycle and lets WE rise one cycle
    // before the address moves.
    // ---------------------------------------------------------------
    always_comb begin
        ready     = (state == DONE) || ((state == IDLE) && !req);

        write_sel = (state == IDLE) ? bus.wr_en        : is_write_q;
        word_sel  = (state == IDLE) ? offset[18:2]     : word_q;
        wdata_sel = (state == IDLE) ? bus.write_data   : wdata_q;

        addr_d    = addr_q;
        dq_d      = dq_q;
        oe_d      = 1'b0;
        we_n_d    = 1'b1;

        if ((state_d == LO) || (state_d == HI)) begin
            addr_d = {word_sel, (state_d == HI)};
            if (write_sel) begin
                dq_d   = (state_d == HI) ? wdata_sel[31:16] : wdata_sel[15:0];
                oe_d   = 1'b1;
                we_n_d = (cnt_d == LAST);
            end
        end
    end

    // ---------------------------------------------------------------
    // Datapath registers: captured request, SRAM pins, load assembly
    // ---------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            word_q     <= '0;
            wdata_q    <= '0;
            is_write_q <= 1'b0;
            addr_q     <= '0;
            dq_q       <= '0;
            oe_q       <= 1'b0;
            we_n_q     <= 1'b1;
            rd_q       <= '0;
        end else begin
            addr_q <= addr_d;
            dq_q   <= dq_d;
            oe_q   <= oe_d;
            we_n_q <= we_n_d;

            if ((state == IDLE) && req) begin
                word_q     <= offset[18:2];
                wdata_q    <= bus.write_data;
                is_write_q <= bus.wr_en;   // write wins when both are set
            end

            // sample at the end of the last cycle of each read phase
            if (!is_write_q && last) begin
                if (state == LO) begin
                    rd_q[15:0] <= bus.sram_dq_in;
                end else if (state == HI) begin
                    rd_q[31:16] <= bus.sram_dq_in;
                end
            end
        end
    end

    assign bus.ready       = ready;
    assign bus.read_data   = rd_q;
    assign bus.sram_addr   = addr_q;
    assign bus.sram_dq_out = dq_q;
    assign bus.sram_dq_oe  = oe_q;
    assign bus.sram_we_n   = we_n_q;

endmodule

// File: tb/tb_sram_ctrl.sv
// tb_sram_ctrl: bench for sram_ctrl. Two instances (ACCESS_CYCLES 2 and 4)
// each sit on a behavioural asynchronous SRAM. A reference model derives
// every cycle's expected outputs from the transaction timeline (cycle index
// since the request was seen) and a reference memory; directed transactions
// additionally pin literal values.
module tb_sram_ctrl;

    localparam int unsigned MEMW = 262144;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    sram_ctrl_if ifc0 ();
    sram_ctrl_if ifc4 ();

    sram_ctrl #(.ACCESS_CYCLES(2), .MEM_BASE(32'd1024)) dut0 (
        .clk (clk),
        .rst (rst_n),
        .bus (ifc0.slave)
    );

    sram_ctrl #(.ACCESS_CYCLES(4), .MEM_BASE(32'd1024)) dut4 (
        .clk (clk),
        .rst (rst_n),
        .bus (ifc4.slave)
    );

    int vectors    = 0;
    int miscompares = 0;

    // behavioural SRAMs and reference memories
    logic [15:0] sram0 [MEMW];
    logic [15:0] sram4 [MEMW];
    logic [15:0] mm0   [MEMW];
    logic [15:0] mm4   [MEMW];

    assign ifc0.sram_dq_in = sram0[ifc0.sram_addr];
    assign ifc4.sram_dq_in = sram4[ifc4.sram_addr];

    always @(negedge clk) begin
        if (ifc0.sram_we_n == 1'b0 && ifc0.sram_dq_oe) sram0[ifc0.sram_addr] = ifc0.sram_dq_out;
        if (ifc4.sram_we_n == 1'b0 && ifc4.sram_dq_oe) sram4[ifc4.sram_addr] = ifc4.sram_dq_out;
    end

    function automatic logic [15:0] pat(input int unsigned a);
        logic [31:0] v;
        v = a;
        return v[15:0] ^ 16'h5A5A;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------------------------------------------------------
    // Reference model: per instance, the cycle index k since C0 decides
    // everything. k in 1..A is the low half, A+1..2A the high half,
    // 2A+1 is the single ready cycle.
    // ---------------------------------------------------------------
    bit          m_act   [2];
    int unsigned m_k     [2];
    bit          m_wr    [2];
    logic [16:0] m_word  [2];
    logic [31:0] m_wdata [2];
    logic [17:0] m_addr  [2];
    logic [15:0] m_dq    [2];
    logic [31:0] m_rd    [2];

    task automatic model_check(input int i, input int unsigned A, input string tag,
                               input logic wr, input logic rd, input logic [31:0] address,
                               input logic [31:0] wdata, input logic ready,
                               input logic [17:0] sa, input logic [15:0] dq,
                               input logic oe, input logic we_n, input logic [31:0] rdata);
        logic        e_ready, e_oe, e_we;
        logic [17:0] e_addr;
        logic [15:0] e_dq;
        logic [31:0] off;
        logic [17:0] idx;
        logic [15:0] hv;
        int unsigned k, pos;
        bit          half, in_phase, done;
        in_phase = 0;
        done     = 0;
        half     = 0;
        pos      = 0;
        if (!rst_n) begin
            m_act[i] = 0;
            m_addr[i] = '0;
            m_dq[i]   = '0;
            m_rd[i]   = '0;
            e_ready = !(wr || rd);
        end else if (!m_act[i]) begin
            if (wr || rd) begin
                m_act[i]   = 1;
                m_k[i]     = 0;
                m_wr[i]    = wr;
                off        = address - 32'd1024;
                m_word[i]  = off[18:2];
                m_wdata[i] = wdata;
                e_ready    = 1'b0;
            end else begin
                e_ready = 1'b1;
            end
        end else begin
            m_k[i]++;
            k = m_k[i];
            if (k <= 2 * A) begin
                in_phase  = 1;
                half      = (k > A);
                pos       = half ? k - A : k;
                e_ready   = 1'b0;
                m_addr[i] = {m_word[i], half};
                if (m_wr[i]) m_dq[i] = half ? m_wdata[i][31:16] : m_wdata[i][15:0];
            end else begin
                e_ready = 1'b1;
                done    = 1;
            end
        end
        e_addr = m_addr[i];
        e_dq   = m_dq[i];
        e_oe   = in_phase && m_wr[i];
        e_we   = !(in_phase && m_wr[i] && pos != A);

        check({tag, " ready"},       ready, e_ready);
        check({tag, " sram_addr"},   sa,    e_addr);
        check({tag, " sram_dq_out"}, dq,    e_dq);
        check({tag, " sram_dq_oe"},  oe,    e_oe);
        check({tag, " sram_we_n"},   we_n,  e_we);
        check({tag, " read_data"},   rdata, m_rd[i]);

        if (in_phase && pos == A) begin
            idx = {m_word[i], half};
            if (m_wr[i]) begin
                hv = half ? m_wdata[i][31:16] : m_wdata[i][15:0];
                if (i == 0) mm0[idx] = hv; else mm4[idx] = hv;
            end else begin
                hv = (i == 0) ? mm0[idx] : mm4[idx];
                if (half) m_rd[i][31:16] = hv; else m_rd[i][15:0] = hv;
            end
        end
        if (done) m_act[i] = 0;
    endtask

    always @(negedge clk) begin
        model_check(0, 2, "u0", ifc0.wr_en, ifc0.rd_en, ifc0.address, ifc0.write_data,
                    ifc0.ready, ifc0.sram_addr, ifc0.sram_dq_out, ifc0.sram_dq_oe,
                    ifc0.sram_we_n, ifc0.read_data);
        model_check(1, 4, "u4", ifc4.wr_en, ifc4.rd_en, ifc4.address, ifc4.write_data,
                    ifc4.ready, ifc4.sram_addr, ifc4.sram_dq_out, ifc4.sram_dq_oe,
                    ifc4.sram_we_n, ifc4.read_data);
    end

    // ---------------------------------------------------------------
    // Driver helpers and per-transaction traces (index 0 = C0)
    // ---------------------------------------------------------------
    logic        tr_ready [64];
    logic [17:0] tr_addr  [64];
    logic [15:0] tr_dq    [64];
    logic        tr_oe    [64];
    logic        tr_we    [64];
    int          tr_n;
    logic [31:0] tr_rd_done;

    task automatic set_in(input int i, input logic wr, input logic rd,
                          input logic [31:0] a, input logic [31:0] d);
        if (i == 0) begin
            ifc0.wr_en = wr; ifc0.rd_en = rd; ifc0.address = a; ifc0.write_data = d;
        end else begin
            ifc4.wr_en = wr; ifc4.rd_en = rd; ifc4.address = a; ifc4.write_data = d;
        end
    endtask

    task automatic idle(input int i);
        @(posedge clk);
        #1;
        set_in(i, 1'b0, 1'b0, 32'd0, 32'd0);
    endtask

    // Present a request and hold it until the ready cycle; the caller's next
    // run() changes the inputs at the edge that ends DONE.
    task automatic run(input int i, input logic wr, input logic rd,
                       input logic [31:0] a, input logic [31:0] d);
        logic r;
        @(posedge clk);
        #1;
        set_in(i, wr, rd, a, d);
        tr_n = -1;
        for (int n = 0; n < 64; n++) begin
            @(negedge clk);
            if (i == 0) begin
                r = ifc0.ready; tr_addr[n] = ifc0.sram_addr; tr_dq[n] = ifc0.sram_dq_out;
                tr_oe[n] = ifc0.sram_dq_oe; tr_we[n] = ifc0.sram_we_n; tr_rd_done = ifc0.read_data;
            end else begin
                r = ifc4.ready; tr_addr[n] = ifc4.sram_addr; tr_dq[n] = ifc4.sram_dq_out;
                tr_oe[n] = ifc4.sram_dq_oe; tr_we[n] = ifc4.sram_we_n; tr_rd_done = ifc4.read_data;
            end
            tr_ready[n] = r;
            if (r) begin
                tr_n = n;
                break;
            end
        end
        if (tr_n < 0) begin
            vectors++;
            miscompares++;
            $display("FAIL ready timeout: got no ready in 64 cycles, expected ready");
        end
    endtask

    function automatic int count_low_we();
        int c;
        c = 0;
        for (int n = 0; n <= tr_n && n < 64; n++) if (tr_we[n] == 1'b0) c++;
        return c;
    endfunction

    function automatic int count_high_oe();
        int c;
        c = 0;
        for (int n = 0; n <= tr_n && n < 64; n++) if (tr_oe[n] == 1'b1) c++;
        return c;
    endfunction

    // ---------------------------------------------------------------
    // Stimulus
    // ---------------------------------------------------------------
    initial begin
        int unsigned r;
        logic [31:0] a, d;

        for (int unsigned j = 0; j < MEMW; j++) begin
            sram0[j] = pat(j); sram4[j] = pat(j);
            mm0[j]   = pat(j); mm4[j]   = pat(j);
        end
        set_in(0, 1'b0, 1'b0, 32'd0, 32'd0);
        set_in(1, 1'b0, 1'b0, 32'd0, 32'd0);
        rst_n = 1'b1;
        #1 rst_n = 1'b0;

        @(negedge clk);
        check("reset read_data", ifc0.read_data, 32'd0);
        check("reset sram_addr", ifc0.sram_addr, 18'd0);
        check("reset sram_dq_out", ifc0.sram_dq_out, 16'd0);
        check("reset sram_dq_oe", ifc0.sram_dq_oe, 1'b0);
        check("reset sram_we_n", ifc0.sram_we_n, 1'b1);
        check("reset ready", ifc0.ready, 1'b1);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;

        // write mapping
        run(0, 1'b1, 1'b0, 32'd1032, 32'hDEADBEEF);
        check("wr latency", tr_n, 5);
        check("wr C1 addr", tr_addr[1], 18'd4);
        check("wr C1 dq", tr_dq[1], 16'hBEEF);
        check("wr C1 we_n", tr_we[1], 1'b0);
        check("wr C1 oe", tr_oe[1], 1'b1);
        check("wr C2 we_n", tr_we[2], 1'b1);
        check("wr C3 addr", tr_addr[3], 18'd5);
        check("wr C3 dq", tr_dq[3], 16'hDEAD);
        check("wr C3 we_n", tr_we[3], 1'b0);
        idle(0);

        // read-back
        run(0, 1'b0, 1'b1, 32'd1032, 32'd0);
        check("rd latency", tr_n, 5);
        check("rd data", tr_rd_done, 32'hDEADBEEF);
        check("rd we_n lows", count_low_we(), 0);
        check("rd oe highs", count_high_oe(), 0);
        idle(0);

        // back-to-back reads
        run(0, 1'b0, 1'b1, 32'd1024, 32'd0);
        check("b2b first data", tr_rd_done, 32'h5A5B5A5A);
        run(0, 1'b0, 1'b1, 32'd1028, 32'd0);
        check("b2b C0 ready", tr_ready[0], 1'b0);
        check("b2b latency", tr_n, 5);
        check("b2b C1 addr", tr_addr[1], 18'd2);
        check("b2b C3 addr", tr_addr[3], 18'd3);
        check("b2b second data", tr_rd_done, 32'h5A595A58);
        idle(0);

        // simultaneous wr_en and rd_en is a write
        run(0, 1'b1, 1'b1, 32'd1024, 32'h12345678);
        check("both C1 addr", tr_addr[1], 18'd0);
        check("both C1 dq", tr_dq[1], 16'h5678);
        check("both C1 we_n", tr_we[1], 1'b0);
        check("both C3 addr", tr_addr[3], 18'd1);
        check("both C3 dq", tr_dq[3], 16'h1234);
        check("both read_data kept", tr_rd_done, 32'h5A595A58);
        idle(0);

        // reset during the high half of a write
        @(posedge clk);
        #1 set_in(0, 1'b1, 1'b0, 32'd1032, 32'hCAFEF00D);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("rst mid we_n", ifc0.sram_we_n, 1'b1);
        check("rst mid oe", ifc0.sram_dq_oe, 1'b0);
        check("rst mid read_data", ifc0.read_data, 32'd0);
        set_in(0, 1'b0, 1'b0, 32'd0, 32'd0);
        @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        check("rst release ready", ifc0.ready, 1'b1);

        // randomized traffic, checked every cycle by the model
        for (int t = 0; t < 200; t++) begin
            r = $urandom_range(0, 9);
            if ($urandom_range(0, 19) == 0) a = $urandom;
            else a = 32'd1024 + 4 * $urandom_range(0, 31) + $urandom_range(0, 3);
            d = $urandom;
            if (r == 9 || $urandom_range(0, 3) == 0) idle(0);
            if (r <= 3)      run(0, 1'b1, 1'b0, a, d);
            else if (r <= 7) run(0, 1'b0, 1'b1, a, d);
            else             run(0, 1'b1, 1'b1, a, d);
            check("rand latency", tr_n, 5);
        end
        idle(0);

        // ACCESS_CYCLES = 4
        run(1, 1'b0, 1'b1, 32'd1036, 32'd0);
        check("a4 rd latency", tr_n, 9);
        check("a4 rd we_n lows", count_low_we(), 0);
        check("a4 rd data", tr_rd_done, 32'h5A5D5A5C);
        run(1, 1'b1, 1'b0, 32'd1040, 32'h0BADF00D);
        check("a4 wr latency", tr_n, 9);
        check("a4 wr C3 we_n", tr_we[3], 1'b0);
        check("a4 wr C4 we_n", tr_we[4], 1'b1);
        check("a4 wr C5 addr", tr_addr[5], 18'd9);
        check("a4 wr C5 dq", tr_dq[5], 16'h0BAD);
        idle(1);
        run(1, 1'b0, 1'b1, 32'd1040, 32'd0);
        check("a4 readback", tr_rd_done, 32'h0BADF00D);
        idle(1);

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion by 200000, expected $finish");
        $fatal(1);
    end

endmodule

// File: doc/sram_ctrl.md
# sram_ctrl

Data-memory controller that sits directly downstream of the MEM stage. It turns one 32-bit load/store request into two 16-bit accesses on an external asynchronous SRAM, and holds `ready` low for the whole transaction. The core's freeze logic uses `ready` to stall every pipeline register until the word has been written, or has been read back and assembled.

## Interface
Parameters:
- `ACCESS_CYCLES`, default 2: clock cycles each 16-bit half-access holds the SRAM bus; legal range 2..15.
- `MEM_BASE`, default 32'd1024: byte address that maps to SRAM word 0.

Ports:
- `clk` input 1: single clock; all state changes on the rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `wr_en` input 1: store request from the MEM stage.
- `rd_en` input 1: load request from the MEM stage.
- `address` input 32: byte address from the ALU result.
- `write_data` input 32: store data (the Rm value).
- `read_data` output 32: assembled load data; valid while `ready` is 1 in DONE.
- `ready` output 1: 1 means the MEM stage may advance; 0 means freeze the pipeline.
- `sram_addr` output 18: SRAM half-word address.
- `sram_dq_out` output 16: write data driven to the SRAM.
- `sram_dq_oe` output 1: 1 enables the external tristate driver on the DQ bus.
- `sram_dq_in` input 16: DQ bus value sampled back from the SRAM.
- `sram_we_n` output 1: SRAM write enable, active-low.

## Operation
- States: IDLE, LO, HI, DONE, held in a 2-bit register plus a cycle counter of width ceil(log2(ACCESS_CYCLES)).
- Address mapping:
  - word = (address − MEM_BASE) >> 2, computed modulo 2^32; `address[1:0]` is ignored.
  - `sram_addr` = {word[16:0], half}, where half is 0 in LO and 1 in HI.
- IDLE:
  - If `wr_en` or `rd_en` is 1, capture `address`, `write_data` and the operation type, then go to LO.
  - If both are asserted, the transaction is a write. Not legal from the core, but the behaviour is defined.
- LO:
  - Drive the low half-word address.
  - On a write: `sram_dq_out` = write_data[15:0], `sram_dq_oe` = 1.
  - `sram_we_n` = 0 in every LO cycle except the last, so WE rises before the address changes.
  - On a read: `sram_we_n` = 1 and `sram_dq_oe` = 0. On the last LO cycle, latch `sram_dq_in` into read_data[15:0].
  - After ACCESS_CYCLES cycles, go to HI.
- HI:
  - Same as LO, with half = 1. Writes drive write_data[31:16]; reads latch into read_data[31:16].
  - After ACCESS_CYCLES cycles, go to DONE.
- DONE: one cycle with `ready` = 1 and the SRAM bus idle. Requests are ignored. Always go to IDLE.
- `ready` (combinational):
  - 1 in DONE.
  - 1 in IDLE when `wr_en` and `rd_en` are both 0.
  - 0 otherwise, including IDLE while a request is present.
- `read_data` holds its last value until the next read overwrites it. Writes do not modify it.
- SRAM outputs are registered. When not in LO/HI: `sram_we_n` = 1, `sram_dq_oe` = 0, and `sram_addr`/`sram_dq_out` hold their last values.
- Reset values:
  - state IDLE, counter 0.
  - `read_data` 0, `sram_addr` 0, `sram_dq_out` 0.
  - `sram_dq_oe` 0, `sram_we_n` 1.
- Reset asserted mid-transaction: abort immediately to the reset values. No partial completion is reported.

## Timing
- Let C0 be the IDLE cycle in which the request is seen.
- LO occupies C1..C(A), HI occupies C(A+1)..C(2A), DONE is C(2A+1), where A = ACCESS_CYCLES.
- `ready` = 0 for cycles C0..C(2A) and 1 in C(2A+1). With A = 2 that is 5 frozen cycles, ready in C5.
- The MEM pipeline register captures `read_data` at the rising edge ending DONE.
- A request held high across that edge (the next instruction) starts a new transaction at C(2A+2), its C0. There is no dead cycle beyond IDLE.
- Read sampling happens at the end of the last cycle of each phase. The SRAM model must present data within A−1 cycles of the address change.

## Test plan
- **Write mapping:** write 0xDEADBEEF at address 1032 (A = 2).
  - C1: `sram_addr` = 4, `sram_dq_out` = 0xBEEF, `sram_we_n` = 0.
  - C3: `sram_addr` = 5, `sram_dq_out` = 0xDEAD, `sram_we_n` = 0.
  - `ready` = 1 only in C5.
- **Read-back:** after the write above, read address 1032 with a behavioural SRAM model. `read_data` = 0xDEADBEEF in DONE, `sram_we_n` stays 1 throughout, `sram_dq_oe` stays 0.
- **Back-to-back:** hold `rd_en` high for two consecutive requests (addresses 1024, then 1028). `ready` pulses high for exactly one cycle between them, and the second access drives `sram_addr` 2, then 3.
- **Simultaneous requests:** `wr_en` = `rd_en` = 1 with write_data 0x12345678 at 1024. The transaction is a write (0x5678 to address 0, then 0x1234 to address 1), and `read_data` is unchanged.
- **Reset mid-transaction:** assert `rst` low during HI of a write. Same cycle: `sram_we_n` = 1, `sram_dq_oe` = 0, `read_data` = 0. After release with no request, `ready` = 1.
- **Parameter sweep:** with ACCESS_CYCLES = 4, a read keeps `ready` at 0 for 9 cycles and 1 on the 10th. `sram_we_n` never goes low.
